// File: rtl/sram_arbiter.sv
// Purpose : arbitrates NUM_CH requesters onto one asynchronous SRAM port (IDLE/SETUP/ACCESS/DONE).
// Latency : ack pulses in the WAIT_CYCLES+2'th cycle after the sampling edge; one access per WAIT_CYCLES+3 cycles.
// Backpressure: requests are sampled only in IDLE; losers keep req high and wait, nothing is queued or dropped.
//
// Ports: clk/rst (sync, active-low); req/we/be/addr/wdata per channel (flattened, channel i at slice i);
//        gnt (one-hot owner), ack (one-cycle completion), rdata (shared, held until next read);
//        SRAM_* active-low strobes, mem_addr/mem_dout/mem_oe/mem_din SRAM data path.
module sram_arbiter #(
    parameter int DATAWIDTH   = 16,
    parameter int ADDRWIDTH   = 16,
    parameter int NUM_CH      = 3,
    parameter int WAIT_CYCLES = 2,
    parameter int RR_MODE     = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              req,
    input  logic [NUM_CH-1:0]              we,
    input  logic [2*NUM_CH-1:0]            be,
    input  logic [ADDRWIDTH*NUM_CH-1:0]    addr,
    input  logic [DATAWIDTH*NUM_CH-1:0]    wdata,
    output logic [NUM_CH-1:0]              gnt,
    output logic [NUM_CH-1:0]              ack,
    output logic [DATAWIDTH-1:0]           rdata,
    output logic                           SRAM_CE,
    output logic                           SRAM_OE,
    output logic                           SRAM_WE,
    output logic                           SRAM_LB,
    output logic                           SRAM_UB,
    output logic [ADDRWIDTH-1:0]           mem_addr,
    output logic [DATAWIDTH-1:0]           mem_dout,
    output logic                           mem_oe,
    input  logic [DATAWIDTH-1:0]           mem_din
);

    localparam int              CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [3:0]      LAST_CNT = 4'(WAIT_CYCLES - 1);
    localparam logic [CHW-1:0]  LAST_CH  = CHW'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t                 state, state_nxt;
    logic [3:0]             cnt;
    logic [CHW-1:0]         last_granted;
    logic [NUM_CH-1:0]      gnt_q;
    logic                   lat_we;
    logic [1:0]             lat_be;
    logic [ADDRWIDTH-1:0]   lat_addr;
    logic [DATAWIDTH-1:0]   lat_wdata;

    // Winner selection and the winner's request fields
    logic [NUM_CH-1:0]      win_oh;
    logic [CHW-1:0]         win_idx;
    logic                   sel_we;
    logic [1:0]             sel_be;
    logic [ADDRWIDTH-1:0]   sel_addr;
    logic [DATAWIDTH-1:0]   sel_wdata;
    logic                   found;
    int                     idx;

    // Search order starts just past the last grant in round-robin mode,
    // or at channel 0 in fixed-priority mode; first requester found wins.
    always_comb begin
        win_oh = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (RR_MODE != 0) begin
                idx = int'(last_granted) + 1 + k;
                if (idx >= NUM_CH) idx = idx - NUM_CH;
            end else begin
                idx = k;
            end
            if (!found && req[idx]) begin
                win_oh[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    always_comb begin
        win_idx   = '0;
        sel_we    = 1'b0;
        sel_be    = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (win_oh[i]) begin
                win_idx   = CHW'(i);
                sel_we    = we[i];
                sel_be    = be[2*i +: 2];
                sel_addr  = addr[i*ADDRWIDTH +: ADDRWIDTH];
                sel_wdata = wdata[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state and strobes; strobes decode from state so a reset edge
    // drops them all in the same cycle the access is aborted.
    always_comb begin
        state_nxt = state;
        SRAM_CE   = 1'b1;
        SRAM_OE   = 1'b1;
        SRAM_WE   = 1'b1;
        SRAM_LB   = 1'b1;
        SRAM_UB   = 1'b1;
        mem_oe    = 1'b0;
        ack       = '0;
        case (state)
            IDLE: begin
                if (|req) state_nxt = SETUP;
            end
            SETUP: begin
                SRAM_CE   = 1'b0;
                SRAM_LB   = ~lat_be[0];
                SRAM_UB   = ~lat_be[1];
                state_nxt = ACCESS;
            end
            ACCESS: begin
                SRAM_CE = 1'b0;
                SRAM_LB = ~lat_be[0];
                SRAM_UB = ~lat_be[1];
                SRAM_OE = lat_we;
                SRAM_WE = ~lat_we;
                mem_oe  = lat_we;
                if (cnt == LAST_CNT) state_nxt = DONE;
            end
            DONE: begin
                ack       = gnt_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, wait counter, read capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            gnt_q        <= '0;
            lat_we       <= 1'b0;
            lat_be       <= '0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            cnt          <= '0;
            rdata        <= '0;
            last_granted <= LAST_CH;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt_q        <= win_oh;
                        lat_we       <= sel_we;
                        lat_be       <= sel_be;
                        lat_addr     <= sel_addr;
                        lat_wdata    <= sel_wdata;
                        last_granted <= win_idx;
                    end
                end
                SETUP:  cnt <= '0;
                ACCESS: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST_CNT && !lat_we) rdata <= mem_din;
                end
                DONE:   gnt_q <= '0;
                default: ;
            endcase
        end
    end

    assign gnt      = gnt_q;
    assign mem_addr = lat_addr;
    assign mem_dout = lat_wdata;

endmodule
